// File: rtl/d5m_cfg_sequencer.sv
// D5M register-table configuration sequencer: walks a per-profile table and
// issues register writes to the serial-bus master with bounded NACK retry.
module d5m_cfg_sequencer #(
  parameter  int ADDR_W    = 8,
  parameter  int DATA_W    = 16,
  parameter  int DEPTH     = 256,
  parameter  int NUM_PROF  = 2,
  parameter  int MAX_RETRY = 3,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int PROF_W    = (NUM_PROF > 1) ? $clog2(NUM_PROF) : 1,
  localparam int ENT_W     = 2 + ADDR_W + DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [PROF_W-1:0]       profile_sel,
  output logic [PROF_W+IDX_W-1:0] tbl_addr,
  input  logic [ENT_W-1:0]        tbl_data,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_reg,
  output logic [DATA_W-1:0]       wr_data,
  input  logic                    rsp_valid,
  input  logic                    rsp_nack,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [IDX_W-1:0]        err_index,
  output logic [IDX_W:0]          wr_count
);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [PROF_W:0]    PROF_LIM  = (PROF_W + 1)'(NUM_PROF);
  localparam logic [PROF_W-1:0]  PROF_MAX  = PROF_W'(NUM_PROF - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_REQ, S_RSP, S_DELAY, S_FIN, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00, OP_DELAY = 2'b01, OP_END = 2'b10, OP_SKIP = 2'b11
  } op_e;

  state_e             r_state, w_next;
  op_e                w_op;
  logic [PROF_W-1:0]  r_prof, w_prof_sel;
  logic [IDX_W-1:0]   r_index, r_err_index;
  logic [RETRY_W-1:0] r_retry;
  logic [DATA_W-1:0]  r_dly;
  logic [ADDR_W-1:0]  r_wr_reg;
  logic [DATA_W-1:0]  r_wr_data;
  logic [IDX_W:0]     r_wr_count;
  logic               w_start_ok, w_last, w_adv;

  assign w_op       = op_e'(tbl_data[ENT_W-1 -: 2]);
  assign w_prof_sel = ({1'b0, profile_sel} >= PROF_LIM) ? PROF_MAX : profile_sel;
  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_FIN || r_state == S_ERR);
  assign w_last     = (r_index == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // w_adv marks "entry finished"; the index step and FIN-on-last share it.
  always_comb begin
    w_next = r_state;
    w_adv  = 1'b0;
    case (r_state)
      S_IDLE, S_FIN, S_ERR: if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_WRITE: w_next = S_REQ;
          OP_DELAY: w_next = S_DELAY;
          OP_END:   w_next = S_FIN;
          default:  w_adv  = 1'b1;
        endcase
      end
      S_REQ: if (wr_ready) w_next = S_RSP;
      S_RSP: begin
        if (rsp_valid) begin
          if (!rsp_nack)                w_adv  = 1'b1;
          else if (r_retry == RETRY_MAX) w_next = S_ERR;
          else                          w_next = S_REQ;
        end
      end
      S_DELAY: if (r_dly == DATA_W'(1)) w_adv = 1'b1;
      default: w_next = S_IDLE;
    endcase
    if (w_adv) w_next = w_last ? S_FIN : S_FETCH;
  end

  always_comb begin
    wr_valid = (r_state == S_REQ);
    busy     = !(r_state == S_IDLE || r_state == S_FIN || r_state == S_ERR);
    done     = (r_state == S_FIN);
    error    = (r_state == S_ERR);
  end

  assign tbl_addr  = {r_prof, r_index};
  assign wr_reg    = r_wr_reg;
  assign wr_data   = r_wr_data;
  assign err_index = r_err_index;
  assign wr_count  = r_wr_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prof      <= '0;
      r_index     <= '0;
      r_retry     <= '0;
      r_dly       <= '0;
      r_wr_reg    <= '0;
      r_wr_data   <= '0;
      r_wr_count  <= '0;
      r_err_index <= '0;
    end else begin
      if (w_start_ok) begin
        r_prof     <= w_prof_sel;
        r_index    <= '0;
        r_retry    <= '0;
        r_wr_count <= '0;
      end
      if (r_state == S_DECODE) begin
        if (w_op == OP_WRITE) begin
          r_wr_reg  <= tbl_data[DATA_W +: ADDR_W];
          r_wr_data <= tbl_data[DATA_W-1:0];
        end
        if (w_op == OP_DELAY)
          r_dly <= (tbl_data[DATA_W-1:0] == '0) ? DATA_W'(1) : tbl_data[DATA_W-1:0];
      end
      if (r_state == S_DELAY) r_dly <= r_dly - DATA_W'(1);
      if (r_state == S_RSP && rsp_valid) begin
        if (!rsp_nack) begin
          r_wr_count <= r_wr_count + (IDX_W + 1)'(1);
          r_retry    <= '0;
        end else if (r_retry == RETRY_MAX) begin
          r_err_index <= r_index;
        end else begin
          r_retry <= r_retry + RETRY_W'(1);
        end
      end
      if (w_adv && !w_last) r_index <= r_index + IDX_W'(1);
    end
  end
endmodule

// File: tb/tb_d5m_cfg_sequencer.sv
// Bench for d5m_cfg_sequencer: directed vector table, reset/restart sequence,
// and randomized tables checked against a table-walking reference model.
module tb_d5m_cfg_sequencer;
  localparam int ADDR_W = 8, DATA_W = 16, DEPTH = 4, NUM_PROF = 2, MAX_RETRY = 3;
  localparam int IDX_W = 2, PROF_W = 1, ENT_W = 26, TA_W = PROF_W + IDX_W;

  typedef logic [DEPTH-1:0][ENT_W-1:0] tbl_t;
  typedef struct {
    logic [PROF_W-1:0] prof;
    tbl_t t;
    int nacks; int hold; int rdly;
    int e_req; bit e_done; bit e_err; int e_cnt; int e_eidx; int e_lat;
  } vec_t;

  localparam logic [ENT_W-1:0] E_END = {2'b10, 24'h000000};
  localparam logic [ENT_W-1:0] E_SKP = {2'b11, 8'h5A, 16'hBEEF};

  logic clk = 1'b0;
  logic rst, start, wr_ready, rsp_valid, rsp_nack;
  logic [PROF_W-1:0] profile_sel;
  logic [TA_W-1:0]   tbl_addr;
  logic [ENT_W-1:0]  tbl_data;
  logic              wr_valid, busy, done, error;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [IDX_W-1:0]  err_index;
  logic [IDX_W:0]    wr_count;

  d5m_cfg_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                      .NUM_PROF(NUM_PROF), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .start(start), .profile_sel(profile_sel),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_reg(wr_reg), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .wr_count(wr_count));

  always #5 clk = ~clk;

  logic [ENT_W-1:0] mem [NUM_PROF*DEPTH];
  always @(posedge clk) tbl_data <= mem[tbl_addr];

  int n_pass = 0, n_tot = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  function automatic logic [ENT_W-1:0] e_w(input logic [7:0] r, input logic [15:0] d);
    return {2'b00, r, d};
  endfunction
  function automatic logic [ENT_W-1:0] e_dly(input logic [15:0] n);
    return {2'b01, 8'h00, n};
  endfunction
  function automatic tbl_t mk(input logic [ENT_W-1:0] a, b, c, d);
    tbl_t t;
    t[0] = a; t[1] = b; t[2] = c; t[3] = d;
    return t;
  endfunction

  task automatic load(input logic [PROF_W-1:0] p, input tbl_t t);
    for (int i = 0; i < DEPTH; i++) begin
      mem[int'(p)*DEPTH + i]    = t[i];
      mem[int'(~p)*DEPTH + i]   = e_w(8'hEE, 16'(i));
    end
  endtask

  // Bus master: programmable stall, response delay and NACK plan.
  bit   nack_q[$];
  bit   plan[$];
  logic [23:0] log_q[$];
  int   hold_left = 0, rsp_dly = 2, rcnt = 0;
  bit   rnd_rdy = 0, junk = 0, pend = 0, prev_v = 0, prev_acc = 0, acc;
  logic [PROF_W-1:0] cur_prof = '0;
  logic [7:0]  prev_reg;
  logic [15:0] prev_data;

  initial begin
    wr_ready = 0; rsp_valid = 0; rsp_nack = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0; prev_v = 0; wr_ready = 0; rsp_valid = 0; rsp_nack = 0;
        continue;
      end
      rsp_valid = 0; rsp_nack = 0;
      if (pend) begin
        if (rcnt == 0) begin
          rsp_valid = 1;
          rsp_nack  = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
          pend = 0;
        end else rcnt--;
      end
      if (busy) chk("tbl_prof", tbl_addr[TA_W-1], cur_prof);
      if (prev_v && !prev_acc) begin
        chk("valid_held", wr_valid, 1);
        if (wr_valid) begin
          chk("reg_stable", wr_reg, prev_reg);
          chk("data_stable", wr_data, prev_data);
        end
      end
      acc = 0;
      if (wr_valid) begin
        if (hold_left > 0) begin wr_ready = 0; hold_left--; end
        else wr_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (junk && !pend && $urandom_range(0, 3) == 0) begin
          rsp_valid = 1; rsp_nack = 1'($urandom_range(0, 1));
        end
        if (wr_ready) begin
          acc = 1; log_q.push_back({wr_reg, wr_data}); pend = 1; rcnt = rsp_dly - 1;
        end
      end else wr_ready = 0;
      prev_v = wr_valid; prev_acc = acc; prev_reg = wr_reg; prev_data = wr_data;
    end
  end

  // Reference model: walk the table by opcode rules, consuming the NACK plan.
  logic [23:0] exp_q[$];
  bit m_done, m_err;
  int m_cnt, m_eidx;
  task automatic model(input tbl_t t);
    int a; bit ok, nk; logic [1:0] op;
    exp_q.delete(); m_done = 0; m_err = 0; m_cnt = 0; m_eidx = 0; a = 0;
    for (int i = 0; i < DEPTH; i++) begin
      op = t[i][ENT_W-1 -: 2];
      if (op == 2'b10) begin m_done = 1; return; end
      if (op == 2'b00) begin
        ok = 0;
        for (int r = 0; r <= MAX_RETRY; r++) begin
          exp_q.push_back(t[i][23:0]);
          nk = (a < plan.size()) ? plan[a] : 1'b0;
          a++;
          if (!nk) begin ok = 1; break; end
        end
        if (!ok) begin m_err = 1; m_eidx = i; return; end
        m_cnt++;
      end
    end
    m_done = 1;
  endtask

  task automatic run_seq(input logic [PROF_W-1:0] prof, input bit spur, output int lat);
    bit fin;
    cur_prof = prof; log_q.delete(); lat = -1; fin = 0;
    @(negedge clk); start = 1; profile_sel = prof;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start = 0;
        chk("busy_rise", busy, 1);
        chk("cnt_clear", wr_count, 0);
        chk("idx0", tbl_addr[IDX_W-1:0], 0);
      end
      if (k == 6) begin start = 0; profile_sel = prof; end
      if (wr_valid && lat < 0) lat = k;
      if (done || error) begin fin = 1; break; end
      if (spur && k == 5 && busy) begin start = 1; profile_sel = ~prof; end
    end
    start = 0;
    chk("finished", fin, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cmp_model();
    chk("n_req", log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) chk("req", log_q[i], exp_q[i]);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("wr_count", wr_count, m_cnt);
    if (m_err) chk("err_index", err_index, m_eidx);
    chk("busy_end", busy, 0);
  endtask

  task automatic chk_zero();
    chk("z_wr_valid", wr_valid, 0);  chk("z_busy", busy, 0);
    chk("z_done", done, 0);          chk("z_error", error, 0);
    chk("z_err_index", err_index, 0); chk("z_wr_count", wr_count, 0);
    chk("z_tbl_addr", tbl_addr, 0);  chk("z_wr_reg", wr_reg, 0);
    chk("z_wr_data", wr_data, 0);
  endtask

  vec_t vecs[8];
  int lat;
  bit got;
  tbl_t rt;
  logic [PROF_W-1:0] rp;
  int unsigned s;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, mk(e_w(8'h01, 16'h0036), e_w(8'h02, 16'h0010), E_END, E_SKP),
                0, 0, 2, 2, 1, 0, 2, 0, 3};
    vecs[1] = '{1'b0, mk(e_w(8'h01, 16'h0036), e_w(8'h02, 16'h0010), E_END, E_SKP),
                0, 5, 2, 2, 1, 0, 2, 0, 3};
    vecs[2] = '{1'b0, mk(E_SKP, e_w(8'h10, 16'h1234), E_END, E_SKP), 3, 0, 2, 4, 1, 0, 1, 0, 5};
    vecs[3] = '{1'b0, mk(E_SKP, e_w(8'h10, 16'h1234), E_END, E_SKP), 4, 0, 2, 4, 0, 1, 0, 1, 5};
    vecs[4] = '{1'b0, mk(e_dly(16'd10), E_SKP, e_w(8'h20, 16'h0040), E_END), 0, 0, 2, 1, 1, 0, 1, 0, 17};
    vecs[5] = '{1'b1, mk(e_w(8'h40, 16'h1), e_w(8'h41, 16'h2), e_w(8'h42, 16'h3), e_w(8'h43, 16'h4)),
                0, 0, 1, 4, 1, 0, 4, 0, 3};
    vecs[6] = '{1'b0, mk(e_dly(16'd0), e_w(8'h30, 16'h0001), E_END, E_SKP), 0, 0, 2, 1, 1, 0, 1, 0, 6};
    vecs[7] = '{1'b1, mk(E_END, e_w(8'h77, 16'h7777), E_SKP, E_SKP), 0, 0, 2, 0, 1, 0, 0, 0, -1};

    rst = 1; start = 0; profile_sel = '0;
    #23;
    chk_zero();
    @(posedge clk); #2 rst = 0;

    foreach (vecs[v]) begin
      load(vecs[v].prof, vecs[v].t);
      plan.delete();
      for (int i = 0; i < vecs[v].nacks; i++) plan.push_back(1'b1);
      nack_q = plan; hold_left = vecs[v].hold; rsp_dly = vecs[v].rdly; rnd_rdy = 0; junk = 0;
      model(vecs[v].t);
      run_seq(vecs[v].prof, 1'b0, lat);
      cmp_model();
      chk("v_req", log_q.size(), vecs[v].e_req);
      chk("v_done", done, vecs[v].e_done);
      chk("v_error", error, vecs[v].e_err);
      chk("v_count", wr_count, vecs[v].e_cnt);
      if (vecs[v].e_err) chk("v_eidx", err_index, vecs[v].e_eidx);
      chk("v_lat", lat, vecs[v].e_lat);
    end

    // Reset while waiting for a response, then restart with a spurious start.
    load(1'b0, vecs[0].t);
    plan.delete(); nack_q = plan; hold_left = 0; rsp_dly = 30; rnd_rdy = 0; junk = 0;
    cur_prof = 1'b0; log_q.delete();
    @(negedge clk); start = 1; profile_sel = 1'b0;
    @(posedge clk); #1 start = 0;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (log_q.size() != 0) begin got = 1; break; end
    end
    chk("rst_req_seen", got, 1);
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1 chk_zero();
    @(posedge clk); #2 rst = 0;
    rsp_dly = 2;
    model(vecs[0].t);
    run_seq(1'b0, 1'b1, lat);
    cmp_model();
    chk("restart_lat", lat, 3);

    for (int r = 0; r < 40; r++) begin
      rp = 1'($urandom_range(0, 1));
      for (int i = 0; i < DEPTH; i++) begin
        s = $urandom_range(0, 9);
        if (s < 6)       rt[i] = e_w(8'($urandom), 16'($urandom));
        else if (s < 8)  rt[i] = e_dly(16'($urandom_range(0, 4)));
        else if (s == 8) rt[i] = E_SKP;
        else             rt[i] = E_END;
      end
      plan.delete();
      for (int i = 0; i < 12; i++)
        plan.push_back((r % 5 == 4 && i < 4) ? 1'b1 : ($urandom_range(0, 3) == 0));
      load(rp, rt);
      nack_q = plan; hold_left = 0; rsp_dly = $urandom_range(1, 3); rnd_rdy = 1; junk = 1;
      model(rt);
      run_seq(rp, 1'($urandom_range(0, 1)), lat);
      cmp_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
